// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states and
// the access-size helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Access size in bytes; illegal encodings fall into the word case and are
  // rejected separately by the decoder.
  function automatic logic [2:0] size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_of = 3'd1;
      F3_H, F3_HU: size_of = 3'd2;
      default:     size_of = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: byte enables and write data for both
// beats, plus little-endian load merge with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata0,
  input  logic [31:0] rdata1,
  output logic [3:0]  be0,
  output logic [3:0]  be1,
  output logic [31:0] wdata0,
  output logic [31:0] wdata1,
  output logic [31:0] rdata_ext
);

  logic [7:0]  lane_mask;
  logic [63:0] wide_w;
  logic [63:0] wide_r;
  logic [31:0] merged;

  // Treat the two words as one 8-lane window; the upper half is the second beat.
  always_comb begin
    lane_mask = ((8'd1 << size) - 8'd1) << off;
    be0       = lane_mask[3:0];
    be1       = lane_mask[7:4];
    wide_w    = {32'd0, wdata} << {off, 3'b000};
    wdata0    = wide_w[31:0];
    wdata1    = wide_w[63:32];
    wide_r    = {rdata1, rdata0} >> {off, 3'b000};
    merged    = wide_r[31:0];
    case (funct3)
      F3_B:    rdata_ext = {{24{merged[7]}}, merged[7:0]};
      F3_H:    rdata_ext = {{16{merged[15]}}, merged[15:0]};
      F3_BU:   rdata_ext = {24'd0, merged[7:0]};
      F3_HU:   rdata_ext = {16'd0, merged[15:0]};
      default: rdata_ext = merged;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Sequential load/store unit between the MEM stage and a word-organised RAM.
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 10,
  parameter bit ALLOW_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] word_q;
  logic [1:0]        off_q;
  logic [2:0]        f3_q;
  logic              we_q, misal_q, err_q;
  logic [31:0]       wdata_q, rdata0_q, res_q;

  logic [1:0]  req_off;
  logic [2:0]  req_size;
  logic        req_illegal, req_misal, req_oor, req_err, accept;
  logic [3:0]  be0, be1;
  logic [31:0] wdata0, wdata1, rdata_ext, merge_lo;

  always_comb begin
    req_off     = req_addr[1:0];
    req_size    = size_of(req_funct3);
    req_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                  (req_we && req_funct3[2]);
    req_misal   = ({2'b00, req_off} + {1'b0, req_size}) > 4'd4;
    // No wrap-around: a split access starting in the last word is out of range.
    req_oor     = (req_addr[XLEN-1:ADDR_W+2] != '0) ||
                  (req_misal && (req_addr[ADDR_W+1:2] == {ADDR_W{1'b1}}));
    req_err     = req_illegal || req_oor || (req_misal && !ALLOW_MISALIGN);
    accept      = req_valid && (state_q == IDLE);
  end

  assign merge_lo = (state_q == BEAT1) ? rdata0_q : mem_rdata;

  lsu_align u_align (
    .off       (off_q),
    .size      (size_of(f3_q)),
    .funct3    (f3_q),
    .wdata     (wdata_q),
    .rdata0    (merge_lo),
    .rdata1    (mem_rdata),
    .be0       (be0),
    .be1       (be1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      word_q   <= '0;
      off_q    <= '0;
      f3_q     <= '0;
      we_q     <= 1'b0;
      misal_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      res_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        word_q  <= req_addr[ADDR_W+1:2];
        off_q   <= req_off;
        f3_q    <= req_funct3;
        we_q    <= req_we;
        misal_q <= req_misal;
        err_q   <= req_err;
        wdata_q <= req_wdata[31:0];
        res_q   <= '0;
      end
      if (state_q == BEAT0 && mem_ack) rdata0_q <= mem_rdata;
      if (mem_req && mem_ack && state_d == RESP) res_q <= we_q ? 32'd0 : rdata_ext;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_err   = (state_q == RESP) && err_q;
    rsp_rdata = (state_q == RESP) ? XLEN'(res_q) : '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE:  if (req_valid) state_d = req_err ? RESP : BEAT0;
      BEAT0: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = word_q;
        mem_be    = be0;
        mem_wdata = wdata0;
        if (mem_ack) state_d = misal_q ? BEAT1 : RESP;
      end
      BEAT1: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = word_q + 1'b1;
        mem_be    = be1;
        mem_wdata = wdata1;
        if (mem_ack) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Sequential load/store unit between the core's MEM stage and a word-organised data RAM.
- Accepts one request at a time over a valid/ready handshake.
- Drives a RAM port with byte enables and wait-state support via mem_ack.
- Splits misaligned accesses into two word beats and returns sign- or zero-extended load data.
- Flags out-of-range addresses and illegal encodings without touching memory.

Parameters:
- XLEN, 32, data and address width of the core side.
- ADDR_W, 10, word-address width of the RAM (RAM depth = 2**ADDR_W words).
- ALLOW_MISALIGN, 1: 1 = split misaligned accesses into two beats; 0 = misaligned access returns rsp_err.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  XLEN  extended load data (0 for stores)
- rsp_err  out  1  access faulted, valid with rsp_valid
- mem_req  out  1  RAM access request
- mem_we  out  1  RAM write
- mem_addr  out  ADDR_W  RAM word address
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned write data
- mem_ack  in  1  RAM completed access; mem_rdata valid this cycle
- mem_rdata  in  32  RAM read data

Behaviour:
- Reset values: FSM in IDLE; req_ready = 1; rsp_valid = 0; rsp_err = 0; rsp_rdata = 0; mem_req = 0; mem_we = 0; mem_be = 0; mem_addr = 0; mem_wdata = 0.
- FSM states: IDLE, BEAT0, BEAT1, RESP.
- req_ready = 1 only in IDLE. A request is accepted on a clock edge where req_valid && req_ready; address, data, funct3 and we are registered.
- Decode at accept:
  - off = addr[1:0]; size = 1, 2 or 4 bytes.
  - Illegal encodings: funct3 011, 110 or 111; or a store with funct3[2] = 1.
  - Misaligned: off + size > 4.
  - Out of range: addr[XLEN-1:ADDR_W+2] != 0, or a misaligned access whose second word (word + 1) would exceed 2**ADDR_W - 1. There is no wrap-around.
  - Any illegal, out-of-range, or (misaligned with ALLOW_MISALIGN = 0) request goes IDLE -> RESP. rsp_err = 1, no mem_req, no partial write.
- Legal request: IDLE -> BEAT0.
  - mem_req = 1, mem_addr = addr[ADDR_W+1:2].
  - mem_be = ((1 << size) - 1) << off, truncated to 4 bits.
  - mem_wdata = wdata << (8*off).
  - mem_req and all mem_* outputs are held stable until the cycle mem_ack = 1. mem_ack while mem_req = 0 is ignored.
- On ack in BEAT0:
  - Single-beat access: go to RESP.
  - Misaligned access: go to BEAT1. mem_addr = word + 1; mem_be = remaining low lanes ((1 << (off + size - 4)) - 1); mem_wdata = wdata >> (8*(4 - off)).
  - mem_req drops for zero cycles between beats: it stays asserted.
- Load merge: beat0 bytes come from lanes off..3, beat1 bytes from lanes 0..; they are assembled little-endian. Then:
  - B and H sign-extend from bit 7 and bit 15 respectively.
  - BU and HU zero-extend.
  - W passes through.
- RESP lasts exactly one cycle: rsp_valid = 1, then IDLE. There is no response backpressure.
- Latency with zero-wait RAM (ack in the first mem_req cycle), counting the accept edge as cycle 0:
  - Aligned access: mem_req in cycle 1, rsp_valid in cycle 2.
  - Misaligned access: rsp_valid in cycle 3.
  - Error: rsp_valid in cycle 1.
  - Each wait cycle adds 1.
- rst asserted in any state:
  - Next edge forces IDLE and clears mem_req and rsp_valid.
  - A store beat already acked stays written; no rollback.
  - No response is issued for the aborted request.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - The state enum: IDLE, BEAT0, BEAT1, RESP.
  - A function size_of(funct3).
- One sub-module, lsu_align: purely combinational. It takes off and size and produces beat0/beat1 byte enables and the shifted write data, and also performs load merge and extension. The FSM lives in lsu_mem_ctrl.

Test Plan:
- Aligned LW at 0x10, mem_rdata = 0xDEADBEEF, zero wait:
  - mem_addr = 4, mem_be = 1111.
  - rsp_valid in cycle 2, rsp_rdata = 0xDEADBEEF.
- LB at 0x13, mem_rdata = 0x80XXXXXX, 3 wait cycles:
  - mem_be = 1000, mem_req held 4 cycles.
  - rsp_rdata = 0xFFFFFF80. Repeating as LBU gives 0x00000080.
- Misaligned SW at 0x22, wdata = 0xAABBCCDD:
  - Beat0: addr 8, be = 1100, wdata = 0xCCDD0000.
  - Beat1: addr 9, be = 0011, wdata low half = 0xAABB.
  - rsp_err = 0.
- Misaligned LH at 0x07 (word1 lane3 = 0x34, word2 lane0 = 0x92): rsp_rdata = 0xFFFF9234.
- Error cases, each expecting rsp_valid in cycle 1 with rsp_err = 1 and mem_req never asserted:
  - Address 0x1000 with ADDR_W = 10.
  - funct3 = 011.
  - SW at 0xFFE (last word + 1 crossing).
  - With ALLOW_MISALIGN = 0: LW at 0x01.
- Reset mid-access: rst asserted during BEAT1 of a misaligned store.
  - Next cycle: mem_req = 0, req_ready = 1, no rsp_valid.
  - A following aligned LW completes normally.
